// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-port arbiter sharing one single-port SRAM.
// Grants one requester per cycle; decodes an address window; routes responses.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   req_i/we_i/be_i/addr_i/wdata_i  per-port request bundle (port p at slice [p])
//   gnt_o                     per-port grant (one-hot or zero, same cycle)
//   rvalid_o/err_o/rdata_o    per-port response, rdata shared
//   mem_*_o                   SRAM request side
//   mem_rvalid_i/mem_rdata_i  SRAM response side
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority, lowest port index wins.

module mem_bus_arbiter #(
    parameter int                   NumPorts   = 2,
    parameter int                   AddrWidth  = 32,
    parameter int                   DataWidth  = 32,
    parameter logic [AddrWidth-1:0] MemStart   = '0,
    parameter int                   MemSize    = 8192,
    parameter int                   MemLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumPorts-1:0]             req_i,
    input  logic [NumPorts-1:0]             we_i,
    input  logic [NumPorts*DataWidth/8-1:0] be_i,
    input  logic [NumPorts*AddrWidth-1:0]   addr_i,
    input  logic [NumPorts*DataWidth-1:0]   wdata_i,
    output logic [NumPorts-1:0]             gnt_o,
    output logic [NumPorts-1:0]             rvalid_o,
    output logic [NumPorts-1:0]             err_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int BeWidth = DataWidth / 8;
    localparam int IdWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(MemSize - 1);

    logic                 any_req;
    logic [IdWidth-1:0]   win;
    logic [AddrWidth-1:0] win_addr;
    logic                 win_in_range;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic [IdWidth-1:0] ptr_q;

    // Search starts at ptr_q and wraps; first requester found wins.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win     = '0;
        for (int k = 0; k < NumPorts; k++) begin
            idx = (int'(ptr_q) + k) % NumPorts;
            if (!any_req && req_i[idx]) begin
                any_req = 1'b1;
                win     = IdWidth'(idx);
            end
        end
        // Nothing is granted while reset is held.
        any_req = any_req & rst_ni;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (any_req) begin
            ptr_q <= (win == IdWidth'(NumPorts - 1)) ? '0 : win + 1'b1;
        end
    end
`else
    // Descending scan: the last hit is the lowest requesting index.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                any_req = 1'b1;
                win     = IdWidth'(k);
            end
        end
        any_req = any_req & rst_ni;
    end
`endif

    always_comb begin
        gnt_o = '0;
        if (any_req) begin
            gnt_o[win] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Window decode and SRAM request
    // ------------------------------------------------------------------
    assign win_addr     = addr_i[int'(win)*AddrWidth +: AddrWidth];
    assign win_in_range = (win_addr & ~OffMask) == MemStart;

    assign mem_req_o   = any_req & win_in_range;
    assign mem_we_o    = mem_req_o & we_i[win];
    assign mem_be_o    = mem_req_o ?
                         be_i[int'(win)*BeWidth +: BeWidth] : '0;
    assign mem_addr_o  = mem_req_o ? (win_addr & OffMask) : '0;
    assign mem_wdata_o = mem_req_o ?
                         wdata_i[int'(win)*DataWidth +: DataWidth] : '0;

    // ------------------------------------------------------------------
    // In-flight ID pipeline, one stage per cycle of memory latency.
    // The write flag forces rdata to 0 for write acknowledgements.
    // ------------------------------------------------------------------
    logic               pl_vld_q [MemLatency];
    logic [IdWidth-1:0] pl_id_q  [MemLatency];
    logic               pl_err_q [MemLatency];
    logic               pl_wr_q  [MemLatency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MemLatency; i++) begin
                pl_vld_q[i] <= 1'b0;
                pl_id_q[i]  <= '0;
                pl_err_q[i] <= 1'b0;
                pl_wr_q[i]  <= 1'b0;
            end
        end else begin
            pl_vld_q[0] <= any_req;
            pl_id_q[0]  <= any_req ? win : '0;
            pl_err_q[0] <= any_req & ~win_in_range;
            pl_wr_q[0]  <= any_req & we_i[win];
            for (int i = 1; i < MemLatency; i++) begin
                pl_vld_q[i] <= pl_vld_q[i-1];
                pl_id_q[i]  <= pl_id_q[i-1];
                pl_err_q[i] <= pl_err_q[i-1];
                pl_wr_q[i]  <= pl_wr_q[i-1];
            end
        end
    end

    logic               tail_vld;
    logic [IdWidth-1:0] tail_id;
    logic               tail_err;
    logic               tail_wr;

    assign tail_vld = pl_vld_q[MemLatency-1];
    assign tail_id  = pl_id_q[MemLatency-1];
    assign tail_err = pl_err_q[MemLatency-1];
    assign tail_wr  = pl_wr_q[MemLatency-1];

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (tail_vld) begin
            rvalid_o[tail_id] = 1'b1;
            err_o[tail_id]    = tail_err;
            if (!tail_err && !tail_wr) begin
                rdata_o = mem_rdata_i;
            end
        end
    end

`ifndef SYNTHESIS
    // The SRAM must answer exactly when an in-window access reaches the tail.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && !(tail_vld && !tail_err)))
                else $error("mem_rvalid_i with no pending in-window access");
            assert (!(tail_vld && !tail_err && !mem_rvalid_i))
                else $error("mem_rvalid_i missing for pending access");
        end
    end
`endif

endmodule
